// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter
// Shares one Avalon-MM master port between the instruction-fetch port (read-only)
// and the data port (load/store). Only one transfer is in flight at a time. The
// winning command is registered and held through waitrequest. The winner gets a
// one-cycle ack. A watchdog aborts transfers that stay stalled too long.
module mips_cpu_bus_arbiter #(
    parameter bit          DATA_PRIORITY  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    // Wide enough to hold TIMEOUT_CYCLES itself; one bit when the watchdog is off.
    localparam int WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t            state;
    state_t            state_next;
    port_t             last_grant;   // also identifies the owner of the current transfer
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_inc;
    logic              any_req;
    logic              pick_d;
    logic              timeout_hit;

    // Arbitration choice and watchdog terminal count.
    always_comb begin
        any_req     = i_req | d_req;
        // Data wins when it is the only requester, when it has fixed priority,
        // or (round-robin) when fetch held the previous grant.
        pick_d      = d_req & (~i_req | DATA_PRIORITY | (last_grant == PORT_I));
        wdog_inc    = wdog + WDOG_W'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && waitrequest
                      && (wdog_inc == WDOG_W'(TIMEOUT_CYCLES));
    end

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: IDLE -> BUS -> RESP -> IDLE.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = BUS;
            BUS:     if (!waitrequest || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded outputs: the ack belongs to whoever owns the transfer now in RESP.
    always_comb begin
        busy  = (state != IDLE);
        i_ack = (state == RESP) && (last_grant == PORT_I);
        d_ack = (state == RESP) && (last_grant == PORT_D);
    end

    // Registered Avalon command, watchdog, returned data and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address     <= '0;
            writedata   <= '0;
            byteenable  <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
            wdog        <= '0;
            last_grant  <= PORT_D;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        wdog <= '0;
                        if (pick_d) begin
                            last_grant <= PORT_D;
                            address    <= d_addr;
                            writedata  <= d_wdata;
                            byteenable <= d_byteenable;
                            read       <= ~d_we;
                            write      <= d_we;
                        end else begin
                            last_grant <= PORT_I;
                            address    <= i_addr;
                            writedata  <= '0;
                            byteenable <= 4'b1111;
                            read       <= 1'b1;
                            write      <= 1'b0;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        // Writes complete without touching the requester's rdata.
                        if (read) begin
                            if (last_grant == PORT_D) d_rdata <= readdata;
                            else                      i_rdata <= readdata;
                        end
                        read  <= 1'b0;
                        write <= 1'b0;
                    end else if (timeout_hit) begin
                        if (last_grant == PORT_D) d_rdata <= '0;
                        else                      i_rdata <= '0;
                        read        <= 1'b0;
                        write       <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
